restoring_divider: RTL
======================

# restoring_divider

Multi-cycle unsigned integer divider for the ALU datapath. It implements the inverse of the adder path: each step is a trial subtraction, a ripple-carry add of the two's complement, which either commits or restores. It takes one dividend/divisor pair per start pulse and produces quotient and remainder after a fixed number of cycles. A start/busy/done handshake connects it to the ALU control FSM.

## Interface
- w, 16, operand/result width in bits (w ≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  w  unsigned; captured on accepted start
- divisor  input  w  unsigned; captured on accepted start
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  w  unsigned quotient
- remainder  output  w  unsigned remainder
- div_by_zero  output  1  set when the captured divisor was 0

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE + start + divisor≠0 → RUN.
  - Capture divisor.
  - Quotient/shift register ← dividend.
  - Partial remainder (w+1 bits) ← 0.
  - Step counter ← w.
  - Clear div_by_zero.
- IDLE + start + divisor=0 → DONE.
  - quotient ← all ones.
  - remainder ← dividend.
  - div_by_zero ← 1.
- RUN, one step per cycle:
  - Shift {partial remainder, quotient register} left by 1.
  - Trial difference = shifted remainder − {0, divisor}, computed in w+1 bits by the subtractor sub-module.
  - If carry-out=1 (no borrow): remainder ← difference, quotient LSB ← 1.
  - Else: remainder unchanged (restored), quotient LSB ← 0.
  - Counter decrements. When it reaches 0 after the step, go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally → IDLE.
- start is ignored in RUN and DONE. No queuing. A start in the DONE cycle is lost.
- quotient, remainder and div_by_zero hold their values from done until the next accepted start. They are not cleared on return to IDLE.
- Intermediate quotient/remainder values are visible during RUN. Consumers must qualify on done.
- Invariant when div_by_zero=0: dividend = quotient·divisor + remainder, and remainder < divisor.
- Reset, including mid-RUN: state ← IDLE; busy, done, div_by_zero ← 0; quotient, remainder ← 0. The aborted operation produces no done.

## Timing
- Accepted start at edge 0 (nonzero divisor):
  - busy high in cycles 1..w.
  - done high in cycle w+1.
  - Total latency w+1 cycles (17 for w=16).
- Divide by zero: done high in cycle 1, busy never asserted.
- Earliest next accepted start: the edge after the done cycle (cycle w+2).
- Throughput: one operation per w+2 cycles.
- The subtractor is purely combinational within one cycle. Its critical path is a (w+1)-bit ripple chain.

## Structure
- Shared package alu_pkg holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - the default width constant ALU_W=16
- One sub-module: ripple_carry_subtractor, parameter w.
  - Computes a − b as a + ~b + 1, with c_in tied to 1.
  - Built from the existing full_adder_cell chain.
  - Outputs diff[w-1:0] and c_out (1 = no borrow).
  - Instantiated once in the divider with width w+1.
- Counter width: $clog2(w+1) bits.

## Test plan
- 100 / 7, w=16 → busy cycles 1–16; done in cycle 17 with quotient=14, remainder=2, div_by_zero=0.
- 0xFFFF / 0x0001 → quotient=0xFFFF, remainder=0. Then 0xFFFF / 0xFFFF → quotient=1, remainder=0.
- 3 / 10 → quotient=0, remainder=3 (dividend smaller than divisor).
- 5 / 0 → done in cycle 1, busy never high, div_by_zero=1, quotient=0xFFFF, remainder=5. The next operation 9/3 clears the flag and returns quotient=3.
- start pulsed in cycles 5 and 17 during a 1000/9 operation → both ignored; a single done with quotient=111, remainder=1.
- rst asserted in cycle 8 of 1000/9 → next cycle: IDLE, busy=0, outputs 0, no done. A fresh 50/5 afterwards gives quotient=10, remainder=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding and default datapath width.
package alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder, the building block of the ripple chains.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/ripple_carry_subtractor.sv
// a - b as a + ~b + 1 over a full_adder_cell ripple chain; c_out=1 means no borrow.
module ripple_carry_subtractor #(
  parameter int w = 17
) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic [w-1:0] diff,
  output logic         c_out
);

  logic [w:0]   carry;
  logic [w-1:0] b_n;

  assign b_n      = ~b;
  assign carry[0] = 1'b1;
  assign c_out    = carry[w];

  for (genvar i = 0; i < w; i++) begin : g_bit
    full_adder_cell u_fa (
      .a    (a[i]),
      .b    (b_n[i]),
      .c_in (carry[i]),
      .sum  (diff[i]),
      .c_out(carry[i+1])
    );
  end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per cycle,
// start/busy/done handshake, quotient all-ones and flag on divide by zero.
module restoring_divider
  import alu_pkg::*;
#(
  parameter int w = ALU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [w-1:0] dividend,
  input  logic [w-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [w-1:0] quotient,
  output logic [w-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(w + 1);

  state_t         state;
  logic [w-1:0]   dvsr;
  logic [w-1:0]   quot;
  logic [w:0]     prem;
  logic [CW-1:0]  cnt;
  logic [w:0]     shifted;
  logic [w:0]     diff;
  logic           no_borrow;
  logic           unused_prem_msb;

  // prem[w] is always 0 after a step (committed diff < divisor), so only the
  // low w bits feed the shift.
  assign shifted         = {prem[w-1:0], quot[w-1]};
  assign unused_prem_msb = prem[w];

  ripple_carry_subtractor #(.w(w + 1)) u_sub (
    .a    (shifted),
    .b    ({1'b0, dvsr}),
    .diff (diff),
    .c_out(no_borrow)
  );

  assign quotient  = quot;
  assign remainder = prem[w-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      dvsr        <= '0;
      quot        <= '0;
      prem        <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              state       <= RUN;
              busy        <= 1'b1;
              dvsr        <= divisor;
              quot        <= dividend;
              prem        <= '0;
              cnt         <= CW'(w);
              div_by_zero <= 1'b0;
            end else begin
              state       <= DONE;
              done        <= 1'b1;
              quot        <= '1;
              prem        <= {1'b0, dividend};
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          if (no_borrow) begin
            prem <= diff;
            quot <= {quot[w-2:0], 1'b1};
          end else begin
            prem <= shifted;
            quot <= {quot[w-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
